// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit bridging a request/response handshake to a single-cycle word RAM
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_excp,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        is_b, is_h, is_w, is_st, mis;
  logic [3:0]  sel;
  logic [31:0] wd, ld;
  logic [7:0]  lb;
  logic [15:0] lh;
  // decode the incoming request: size class, misalignment, big-endian lane select, replicated store data
  always_comb begin
    is_b  = req_op inside {3'b000, 3'b001, 3'b101};
    is_h  = req_op inside {3'b010, 3'b011, 3'b110};
    is_w  = !is_b && !is_h;
    is_st = req_op[2] && (req_op[1:0] != 2'b00);
    mis   = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
    sel   = is_b ? 4'b1000 >> req_addr[1:0] : is_h ? (req_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wd    = !is_st ? 32'd0 : is_b ? {4{req_wdata[7:0]}} : is_h ? {2{req_wdata[15:0]}} : req_wdata;
  end
  // pick the addressed lane out of the RAM word and extend it according to the latched opcode
  always_comb begin
    lb = 8'(ram_rdata >> {~off_q, 3'b000});
    lh = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    ld = op_q == 3'b000 ? {{24{lb[7]}}, lb} :
         op_q == 3'b001 ? {24'd0, lb} :
         op_q == 3'b010 ? {{16{lh[15]}}, lh} :
         op_q == 3'b011 ? {16'd0, lh} :
         op_q == 3'b100 ? ram_rdata : 32'd0;
  end
  // IDLE -> ACCESS -> RESP controller; all outputs registered and cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      op_q       <= '0;
      off_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_excp  <= 1'b0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_sel    <= '0;
      ram_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q      <= req_op;
          off_q     <= req_addr[1:0];
          req_ready <= 1'b0;
          if (mis) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_excp  <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state     <= ACCESS;
            ram_ce    <= 1'b1;
            ram_we    <= is_st;
            ram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            ram_sel   <= sel;
            ram_wdata <= wd;
          end
        end
        ACCESS: begin
          state      <= RESP;
          ram_ce     <= 1'b0;
          ram_we     <= 1'b0;
          ram_addr   <= '0;
          ram_sel    <= '0;
          ram_wdata  <= '0;
          resp_valid <= 1'b1;
          resp_excp  <= 1'b0;
          resp_rdata <= ld;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_excp  <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
